// File: rtl/contador_updown.sv
// Bidirectional range-limited counter with wrap, saturate, bounce and one-shot modes.
// Synchronous load with clamping and a registered terminal-count pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | counting allowed on enabled cycles
// S_STOPPED| one-shot finished; holds until the next load
module contador_updown #(
    parameter int WIDTH = 4,
    parameter int CMIN  = 0,
    parameter int CMAX  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mdir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] cont,
    output logic             dir_q,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] LO = WIDTH'(CMIN);
    localparam logic [WIDTH-1:0] HI = WIDTH'(CMAX);

    localparam logic [1:0] M_WRAP    = 2'b00;
    localparam logic [1:0] M_SAT     = 2'b01;
    localparam logic [1:0] M_BOUNCE  = 2'b10;

    typedef enum logic {S_RUN, S_STOPPED} state_t;
    state_t state;

    logic             d;
    logic             sd;
    logic             at_lim;
    logic             arrive;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    // sd is the direction the step actually moves; it differs from d only
    // when bounce mode starts a step sitting on the limit it is heading for.
    always_comb begin
        d        = (mode == M_BOUNCE) ? dir_q : mdir;
        at_lim   = d ? (cont == LO) : (cont == HI);
        sd       = d;
        if (mode == M_BOUNCE && at_lim)
            sd = ~d;
        step_val = sd ? (cont - 1'b1) : (cont + 1'b1);
        arrive   = sd ? (step_val == LO) : (step_val == HI);
    end

    always_comb begin
        load_clamped = load_val;
        if (int'(load_val) < CMIN)
            load_clamped = LO;
        else if (int'(load_val) > CMAX)
            load_clamped = HI;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cont  <= LO;
            dir_q <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
            state <= S_RUN;
        end else begin
            tc <= 1'b0;
            if (load) begin
                cont  <= load_clamped;
                dir_q <= mdir;
                done  <= 1'b0;
                state <= S_RUN;
            end else if (en && state == S_RUN) begin
                case (mode)
                    M_WRAP: begin
                        dir_q <= d;
                        if (at_lim) begin
                            cont <= d ? HI : LO;
                        end else begin
                            cont <= step_val;
                            tc   <= arrive;
                        end
                    end
                    M_SAT: begin
                        dir_q <= d;
                        if (!at_lim) begin
                            cont <= step_val;
                            tc   <= arrive;
                        end
                    end
                    M_BOUNCE: begin
                        cont  <= step_val;
                        tc    <= arrive;
                        dir_q <= arrive ? ~sd : sd;
                    end
                    default: begin
                        dir_q <= d;
                        if (!at_lim) begin
                            cont <= step_val;
                            tc   <= arrive;
                            if (arrive) begin
                                done  <= 1'b1;
                                state <= S_STOPPED;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_contador_updown.sv
// Directed bench for contador_updown: each mode, load clamping/priority and async reset.
module tb_contador_updown;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       mdir;
    logic [1:0] mode;
    logic [3:0] cont;
    logic       dir_q;
    logic       tc;
    logic       done;

    int checks   = 0;
    int failures = 0;

    contador_updown #(.WIDTH(4), .CMIN(0), .CMAX(9)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mdir     (mdir),
        .mode     (mode),
        .cont     (cont),
        .dir_q    (dir_q),
        .tc       (tc),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int val, input logic dir);
        load     = 1'b1;
        load_val = 4'(val);
        mdir     = dir;
        tick();
        load     = 1'b0;
    endtask

    int wrap_up[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int wrap_dn[4]  = '{1, 0, 9, 8};
    int sat_up[4]   = '{8, 9, 9, 9};
    int sat_tc[4]   = '{0, 1, 0, 0};
    int bnc[11]     = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mdir = 1'b0; mode = 2'b00;
        #12;
        check_val("rst_cont", int'(cont), 0);
        check_val("rst_dir", int'(dir_q), 0);
        check_val("rst_tc", int'(tc), 0);
        check_val("rst_done", int'(done), 0);
        reset = 1'b1;

        // count 0..9, then asynchronous reset between edges
        en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check_val("t1_cont", int'(cont), i);
            check_val("t1_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        #2 reset = 1'b0;
        #1;
        check_val("t1_async_cont", int'(cont), 0);
        check_val("t1_async_dir", int'(dir_q), 0);
        check_val("t1_async_tc", int'(tc), 0);
        #2 reset = 1'b1;

        // wrap up then down
        for (int i = 0; i < 11; i++) begin
            tick();
            check_val("wrap_up_cont", int'(cont), wrap_up[i]);
            check_val("wrap_up_tc", int'(tc), (wrap_up[i] == 9) ? 1 : 0);
        end
        do_load(2, 1'b1);
        check_val("wrap_ld_cont", int'(cont), 2);
        check_val("wrap_ld_dir", int'(dir_q), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("wrap_dn_cont", int'(cont), wrap_dn[i]);
            check_val("wrap_dn_tc", int'(tc), (wrap_dn[i] == 0) ? 1 : 0);
        end

        // saturate
        mode = 2'b01;
        do_load(7, 1'b0);
        check_val("sat_ld_cont", int'(cont), 7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("sat_cont", int'(cont), sat_up[i]);
            check_val("sat_tc", int'(tc), sat_tc[i]);
        end
        mdir = 1'b1;
        tick();
        check_val("sat_dn_cont", int'(cont), 8);
        check_val("sat_dn_dir", int'(dir_q), 1);
        check_val("sat_dn_tc", int'(tc), 0);

        // bounce, mdir forced opposite after load
        mode = 2'b10;
        do_load(8, 1'b0);
        check_val("bnc_ld_cont", int'(cont), 8);
        mdir = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            check_val("bnc_cont", int'(cont), bnc[i]);
            check_val("bnc_tc", int'(tc), (i == 0 || i == 9) ? 1 : 0);
            check_val("bnc_dir", int'(dir_q), (i <= 8) ? 1 : 0);
        end

        // one-shot
        mode = 2'b11;
        do_load(2, 1'b1);
        tick();
        check_val("os_cont1", int'(cont), 1);
        check_val("os_done1", int'(done), 0);
        tick();
        check_val("os_cont0", int'(cont), 0);
        check_val("os_tc0", int'(tc), 1);
        check_val("os_done0", int'(done), 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("os_hold_cont", int'(cont), 0);
            check_val("os_hold_tc", int'(tc), 0);
            check_val("os_hold_done", int'(done), 1);
        end
        do_load(5, 1'b1);
        check_val("os_reld_cont", int'(cont), 5);
        check_val("os_reld_done", int'(done), 0);
        tick();
        check_val("os_resume", int'(cont), 4);

        // load clamp, load-over-enable priority, load out of STOPPED
        do_load(12, 1'b1);
        check_val("clamp_cont", int'(cont), 9);
        do_load(3, 1'b1);
        check_val("ld_pri_cont", int'(cont), 3);
        for (int i = 2; i >= 0; i--) begin
            tick();
            check_val("os2_cont", int'(cont), i);
        end
        check_val("os2_done", int'(done), 1);
        tick();
        check_val("os2_hold", int'(cont), 0);
        do_load(0, 1'b0);
        check_val("stop_ld_cont", int'(cont), 0);
        check_val("stop_ld_done", int'(done), 0);
        tick();
        check_val("stop_ld_run", int'(cont), 1);

        // reset asserted while a load is pending
        load = 1'b1; load_val = 4'd6;
        #2 reset = 1'b0;
        #1;
        check_val("rst_mid_load_cont", int'(cont), 0);
        check_val("rst_mid_load_done", int'(done), 0);
        load = 1'b0;
        #2 reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
